// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns the trap CSRs and drives the
// flush/save/redirect sequence for exceptions, interrupts and MRET.
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit          VECTORED    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_exc_req,
    input  logic [5:0]  i_exc_cause,
    input  logic [31:0] i_exc_tval,
    input  logic [31:0] i_exc_pc,
    input  logic        i_mret_req,
    input  logic [31:0] i_next_pc,
    input  logic        i_irq_ext,
    input  logic        i_irq_sw,
    input  logic        i_irq_timer,
    input  logic        i_csr_we,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    output logic        o_flush_all,
    output logic        o_set_pc_valid,
    output logic [31:0] o_set_pc,
    output logic        o_irq_ack,
    output logic [4:0]  o_irq_ack_id,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SAVE,
        S_REDIRECT,
        S_MRET
    } state_t;

    state_t      r_state;
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_cause;
    logic [31:0] r_tval;
    logic [31:0] r_epc;
    logic        r_flush;
    logic        r_pc_valid;
    logic [31:0] r_set_pc;
    logic        r_ack;
    logic [4:0]  r_ack_id;

    logic [31:0] w_mip;
    logic [31:0] w_pend;
    logic        w_irq;
    logic [4:0]  w_irq_id;
    logic [31:0] w_mstatus;
    logic [31:0] w_mtvec_wr;
    logic [31:0] w_vec_off;
    logic [31:0] w_trap_pc;

    assign w_mip = {20'b0, i_irq_ext, 3'b0, i_irq_timer, 3'b0, i_irq_sw, 3'b0};
    assign w_pend = w_mip & r_mie;
    assign w_irq = r_mstatus_mie & (|w_pend);
    assign w_mstatus = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
    assign w_mtvec_wr = {i_csr_wdata[31:2], 1'b0, VECTORED ? i_csr_wdata[0] : 1'b0};
    assign w_vec_off = (r_cause[31] && r_mtvec[0]) ? {25'b0, r_cause[4:0], 2'b00} : 32'b0;
    assign w_trap_pc = {r_mtvec[31:2], 2'b00} + w_vec_off;

    // Fixed interrupt priority: external, then software, then timer.
    always_comb begin
        w_irq_id = 5'd0;
        if (w_pend[11])
            w_irq_id = 5'd11;
        else if (w_pend[3])
            w_irq_id = 5'd3;
        else if (w_pend[7])
            w_irq_id = 5'd7;
    end

    // Combinational CSR read mux; unmapped addresses read zero.
    always_comb begin
        o_csr_rdata = 32'b0;
        case (i_csr_addr)
            12'h300: o_csr_rdata = w_mstatus;
            12'h304: o_csr_rdata = r_mie;
            12'h305: o_csr_rdata = r_mtvec;
            12'h341: o_csr_rdata = r_mepc;
            12'h342: o_csr_rdata = r_mcause;
            12'h343: o_csr_rdata = r_mtval;
            12'h344: o_csr_rdata = w_mip;
            default: o_csr_rdata = 32'b0;
        endcase
    end

    // Trap FSM plus CSR state; trap updates are placed after CSR writes so they win.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'b0;
            r_mtvec        <= MTVEC_RESET;
            r_mepc         <= 32'b0;
            r_mcause       <= 32'b0;
            r_mtval        <= 32'b0;
            r_cause        <= 32'b0;
            r_tval         <= 32'b0;
            r_epc          <= 32'b0;
            r_flush        <= 1'b0;
            r_pc_valid     <= 1'b0;
            r_set_pc       <= 32'b0;
            r_ack          <= 1'b0;
            r_ack_id       <= 5'd0;
        end else begin
            r_flush    <= 1'b0;
            r_pc_valid <= 1'b0;
            r_ack      <= 1'b0;
            r_ack_id   <= 5'd0;
            if (i_csr_we) begin
                case (i_csr_addr)
                    12'h300: begin
                        r_mstatus_mie  <= i_csr_wdata[3];
                        r_mstatus_mpie <= i_csr_wdata[7];
                    end
                    12'h304: r_mie <= i_csr_wdata & 32'h0000_0888;
                    12'h305: r_mtvec <= w_mtvec_wr;
                    12'h341: r_mepc <= {i_csr_wdata[31:2], 2'b00};
                    12'h342: r_mcause <= i_csr_wdata;
                    12'h343: r_mtval <= i_csr_wdata;
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE: begin
                    if (i_exc_req) begin
                        r_epc   <= i_exc_pc;
                        r_cause <= {26'b0, i_exc_cause};
                        r_tval  <= i_exc_tval;
                        r_flush <= 1'b1;
                        r_state <= S_FLUSH;
                    end else if (i_mret_req) begin
                        r_flush    <= 1'b1;
                        r_pc_valid <= 1'b1;
                        r_set_pc   <= r_mepc;
                        r_state    <= S_MRET;
                    end else if (w_irq) begin
                        r_epc   <= i_next_pc;
                        r_cause <= {1'b1, 26'b0, w_irq_id};
                        r_tval  <= 32'b0;
                        r_flush <= 1'b1;
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_flush <= 1'b1;
                    r_state <= S_SAVE;
                end
                S_SAVE: begin
                    r_mepc         <= {r_epc[31:2], 2'b00};
                    r_mcause       <= r_cause;
                    r_mtval        <= r_tval;
                    r_mstatus_mpie <= r_mstatus_mie;
                    r_mstatus_mie  <= 1'b0;
                    r_flush        <= 1'b1;
                    r_pc_valid     <= 1'b1;
                    r_set_pc       <= w_trap_pc;
                    r_ack          <= r_cause[31];
                    r_ack_id       <= r_cause[31] ? r_cause[4:0] : 5'd0;
                    r_state        <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    r_state <= S_IDLE;
                end
                S_MRET: begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_flush_all    = r_flush;
    assign o_set_pc_valid = r_pc_valid;
    assign o_set_pc       = r_set_pc;
    assign o_irq_ack      = r_ack;
    assign o_irq_ack_id   = r_ack_id;
    assign o_busy         = (r_state != S_IDLE);

endmodule
